tt_logic_cell: RTL and testbench
================================

# tt_logic_cell

Parametrised, runtime-reprogrammable N-input truth-table gate for the genetic-circuit logic library. It replaces fixed per-function NOR/NOT netlists with one cell whose Boolean function is a loadable truth table (power-up function 0x0304). It adds a settling filter that models promoter/repressor response delay: the output updates only after the inputs have held steady for SETTLE cycles. It sits between the input-sensor registers and downstream gate cells or reporter logic.

## Interface
- N_IN, 4, number of logic inputs (1..6)
- TT_INIT, 16'h0304, power-up truth table, width 2**N_IN; bit i = output for input value i
- SETTLE, 3, cycles of input stability required before the output updates (0..255)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in  input  N_IN  logic inputs; in[0] is the LSB of the table index
- cfg_valid  input  1  config bit offered
- cfg_ready  output  1  config bit accepted when cfg_valid & cfg_ready
- cfg_bit  input  1  truth-table bit, sent LSB (index 0) first
- cfg_last  input  1  marks table bit 2**N_IN-1
- cfg_err  output  1  sticky framing error
- out  output  1  settled function output
- out_valid  output  1  out reflects the current held input under the active table

## Operation
- Reset values: active table = TT_INIT, in_q = 0, cnt = 0, out = 0, out_valid = 0, cfg_ready = 1, cfg_err = 0, FSM = IDLE, bit counter = 0, shadow = 0.
- Input stage: each edge, if in != in_q, then in_q <= in, cnt <= 0, out_valid <= 0. Otherwise cnt increments, saturating at SETTLE.
- When cnt == SETTLE: out <= table[in_q] and out_valid <= 1. While unsettled, out holds its previous value (glitch suppression).
- Config FSM:
  - IDLE: first accepted bit goes to LOAD.
  - LOAD: each accepted bit is written to shadow[idx], then idx++.
  - Accepted bit with cfg_last and idx == 2**N_IN-1 goes to COMMIT.
  - cfg_last at any other idx, or a bit at idx == 2**N_IN-1 without cfg_last, sets cfg_err. The shadow is discarded, idx is cleared, and the FSM returns to IDLE with no commit.
  - COMMIT (1 cycle, cfg_ready = 0): active table <= shadow, cnt <= 0, out_valid <= 0, then return to IDLE.
- cfg_ready = 1 in IDLE and LOAD.
- The old table stays in use throughout LOAD.
- cfg_err clears only on reset.

## Timing
- Input change sampled at edge k: out and out_valid update at edge k+SETTLE+1. SETTLE=0 gives 1-cycle latency.
- An input toggle before settling restarts the count. out keeps its old value and out_valid stays 0.
- Commit at edge c: re-evaluation with the new table completes at edge c+SETTLE+1.
- Commit and input change in the same cycle: both clear cnt, and there is a single restart.
- cfg_ready drops for exactly one cycle per commit. A load takes at least 2**N_IN+1 cycles.
- Asynchronous reset mid-load or mid-settle: all state returns immediately to reset values, including table = TT_INIT.

## Structure
- Shared package cello_tt_pkg: FSM enum (IDLE, LOAD, COMMIT), function tt_width(n) = 2**n, counter-width helper based on $clog2.
- One sub-module, settle_filter (generic width/SETTLE stability detector producing a stable pulse and the held value). It is also used by the future reporter-output cell.
- Top level: config FSM, shadow and active tables, index mux.

## Test plan
- Reset defaults, N_IN=4, SETTLE=3: hold in=2, 9, 8, 0 in turn. Required out = 1, 1, 1, 0, each with out_valid rising exactly 4 cycles after the change.
- Glitch: in goes 0 -> 2 for 2 cycles -> 0. Required: out stays 0 and out_valid drops, then returns high 4 cycles after the return to 0.
- Reprogram to 16'h8000 (AND4) with in=15 held. Required: cfg_ready low for 1 cycle after the last bit, and out goes 0 -> 1 at commit+4.
- Framing error: cfg_last on bit 7. Required: cfg_err = 1, table still 0x0304 (in=2 gives 1), and a following correct load succeeds.
- Load in progress with input changes: old table outputs remain correct until commit.
- Assert rst_n low mid-load and mid-settle. Required: all outputs at reset values the same cycle, and TT_INIT behaviour after release.

Source files
------------

// File: rtl/cello_tt_pkg.sv
// Shared types and sizing helpers for the genetic-circuit truth-table cells.
package cello_tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT
   } cfg_state_t;

   function automatic int unsigned tt_width(input int unsigned n);
      return 32'd1 << n;
   endfunction

   // Counter width able to hold 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tt_logic_cell_if.sv
// Logic inputs, serial truth-table load channel and settled output of tt_logic_cell.
interface tt_logic_cell_if #(
   parameter int unsigned N_IN = 4
);
   logic [N_IN-1:0] in;
   logic            cfg_valid;
   logic            cfg_ready;
   logic            cfg_bit;
   logic            cfg_last;
   logic            cfg_err;
   logic            out;
   logic            out_valid;

   modport master (
      output in, cfg_valid, cfg_bit, cfg_last,
      input  cfg_ready, cfg_err, out, out_valid
   );

   modport slave (
      input  in, cfg_valid, cfg_bit, cfg_last,
      output cfg_ready, cfg_err, out, out_valid
   );
endinterface

// File: rtl/settle_filter.sv
// Generic stability detector: holds the last sampled value and flags it stable
// once it has been unchanged for SETTLE cycles since the last change or restart.
module settle_filter
   import cello_tt_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             restart,
   output logic [WIDTH-1:0] held,
   output logic             stable
);

   localparam int unsigned      CW      = cnt_width(SETTLE);
   localparam logic [CW-1:0]    CNT_MAX = CW'(SETTLE);

   logic [CW-1:0] cnt;
   logic          changed;

   assign changed = (d != held);
   // A change or restart seen this edge wins over a count that has just saturated.
   assign stable  = !changed && !restart && (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= '0;
         cnt  <= '0;
      end else if (changed) begin
         held <= d;
         cnt  <= '0;
      end else if (restart) begin
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tt_logic_cell.sv
// Runtime-reprogrammable N-input truth-table gate with a settling filter on its inputs
// and a serial, LSB-first table loader that commits atomically.
module tt_logic_cell
   import cello_tt_pkg::*;
#(
   parameter int unsigned                  N_IN    = 4,
   parameter logic [tt_width(N_IN)-1:0]    TT_INIT = 16'h0304,
   parameter int unsigned                  SETTLE  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   tt_logic_cell_if.slave  bus
);

   localparam int unsigned     TW      = tt_width(N_IN);
   localparam logic [N_IN-1:0] IDX_MAX = '1;

   cfg_state_t      state;
   logic [TW-1:0]   active_tt;
   logic [TW-1:0]   shadow;
   logic [N_IN-1:0] idx;
   logic [N_IN-1:0] in_q;
   logic            stable;
   logic            accept;
   logic            commit;

   assign accept = bus.cfg_valid & bus.cfg_ready;
   assign commit = (state == COMMIT);

   settle_filter #(
      .WIDTH  (N_IN),
      .SETTLE (SETTLE)
   ) u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (bus.in),
      .restart (commit),
      .held    (in_q),
      .stable  (stable)
   );

   // out_valid tracks stable directly: any unsettled period began with a change or
   // commit edge, which already dropped it, so no separate clear term is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out       <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= stable;
         if (stable) begin
            bus.out <= active_tt[in_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         shadow        <= '0;
         active_tt     <= TT_INIT;
         bus.cfg_ready <= 1'b1;
         bus.cfg_err   <= 1'b0;
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  if (bus.cfg_last && (idx == IDX_MAX)) begin
                     shadow[idx]   <= bus.cfg_bit;
                     state         <= COMMIT;
                     bus.cfg_ready <= 1'b0;
                  end else if (bus.cfg_last || (idx == IDX_MAX)) begin
                     // Framing error: drop the partial table, keep the active one.
                     bus.cfg_err <= 1'b1;
                     shadow      <= '0;
                     idx         <= '0;
                     state       <= IDLE;
                  end else begin
                     shadow[idx] <= bus.cfg_bit;
                     idx         <= idx + 1'b1;
                     state       <= LOAD;
                  end
               end
            end
            COMMIT: begin
               active_tt     <= shadow;
               shadow        <= '0;
               idx           <= '0;
               state         <= IDLE;
               bus.cfg_ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_logic_cell.sv
// Directed self-checking bench for tt_logic_cell (N_IN=4, TT_INIT=16'h0304, SETTLE=3).
module tb_tt_logic_cell;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   tt_logic_cell_if #(.N_IN(4)) bus ();

   tt_logic_cell #(
      .N_IN    (4),
      .TT_INIT (16'h0304),
      .SETTLE  (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Count edges after the change edge until out_valid rises (bounded), then check value.
   task automatic settle_wait(input string tag, input logic exp_out);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.out_valid !== 1'b1 && n < 20);
      check({tag, " latency"}, n, 4);
      check({tag, " out"}, {31'd0, bus.out}, {31'd0, exp_out});
   endtask

   // Drive a new input and check the change edge drops out_valid while out holds.
   task automatic apply_in(input string tag, input logic [3:0] v, input logic held_out);
      bus.in = v;
      step();
      check({tag, " valid drop"}, {31'd0, bus.out_valid}, 0);
      check({tag, " out held"}, {31'd0, bus.out}, {31'd0, held_out});
   endtask

   task automatic send_bit(input string tag, input logic b, input logic last);
      check({tag, " ready"}, {31'd0, bus.cfg_ready}, 1);
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = b;
      bus.cfg_last  = last;
      step();
   endtask

   initial begin
      logic [15:0] tt;
      n_assert = 0;
      n_fail   = 0;
      rst_n         = 1'b0;
      bus.in        = 4'd0;
      bus.cfg_valid = 1'b0;
      bus.cfg_bit   = 1'b0;
      bus.cfg_last  = 1'b0;

      #12;
      check("reset out", {31'd0, bus.out}, 0);
      check("reset out_valid", {31'd0, bus.out_valid}, 0);
      check("reset cfg_ready", {31'd0, bus.cfg_ready}, 1);
      check("reset cfg_err", {31'd0, bus.cfg_err}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      repeat (5) step();
      check("idle in0 valid", {31'd0, bus.out_valid}, 1);
      check("idle in0 out", {31'd0, bus.out}, 0);

      apply_in("in2", 4'd2, 1'b0);
      settle_wait("in2", 1'b1);
      apply_in("in9", 4'd9, 1'b1);
      settle_wait("in9", 1'b1);
      apply_in("in8", 4'd8, 1'b1);
      settle_wait("in8", 1'b1);
      apply_in("in0", 4'd0, 1'b1);
      settle_wait("in0", 1'b0);

      // Glitch: in=2 for two sampled edges, then back to 0.
      bus.in = 4'd2;
      step();
      check("glitch valid k", {31'd0, bus.out_valid}, 0);
      step();
      check("glitch valid k+1", {31'd0, bus.out_valid}, 0);
      check("glitch out k+1", {31'd0, bus.out}, 0);
      bus.in = 4'd0;
      step();
      check("glitch valid back", {31'd0, bus.out_valid}, 0);
      check("glitch out back", {31'd0, bus.out}, 0);
      settle_wait("glitch", 1'b0);

      // Framing error: cfg_last on index 7.
      for (int i = 0; i < 8; i++) send_bit("frame", 1'b0, i == 7);
      bus.cfg_valid = 1'b0;
      bus.cfg_last  = 1'b0;
      check("frame cfg_err", {31'd0, bus.cfg_err}, 1);
      check("frame ready", {31'd0, bus.cfg_ready}, 1);
      step();
      check("frame no commit", {31'd0, bus.cfg_ready}, 1);
      apply_in("frame in2", 4'd2, 1'b0);
      settle_wait("frame in2", 1'b1);

      // Reprogram to AND4 with in=15 held.
      apply_in("and in15", 4'd15, 1'b1);
      settle_wait("and in15", 1'b0);
      tt = 16'h8000;
      for (int i = 0; i < 16; i++) send_bit("and load", tt[i], i == 15);
      bus.cfg_valid = 1'b0;
      bus.cfg_last  = 1'b0;
      check("and ready low", {31'd0, bus.cfg_ready}, 0);
      check("and old valid", {31'd0, bus.out_valid}, 1);
      check("and old out", {31'd0, bus.out}, 0);
      step();
      check("and ready back", {31'd0, bus.cfg_ready}, 1);
      check("and commit valid", {31'd0, bus.out_valid}, 0);
      check("and commit out", {31'd0, bus.out}, 0);
      settle_wait("and commit", 1'b1);
      apply_in("and in2", 4'd2, 1'b1);
      settle_wait("and in2", 1'b0);

      // Load NOR4 while inputs move; old AND4 table must stay in use.
      tt = 16'h0001;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) bus.in = 4'd14;
         if (i == 8) bus.in = 4'd15;
         send_bit("nor load", tt[i], i == 15);
         if (i == 7) begin
            check("nor old in14 valid", {31'd0, bus.out_valid}, 1);
            check("nor old in14 out", {31'd0, bus.out}, 0);
         end
         if (i == 14) begin
            check("nor old in15 valid", {31'd0, bus.out_valid}, 1);
            check("nor old in15 out", {31'd0, bus.out}, 1);
         end
      end
      bus.cfg_valid = 1'b0;
      bus.cfg_last  = 1'b0;
      check("nor ready low", {31'd0, bus.cfg_ready}, 0);
      bus.in = 4'd0;
      step();
      check("nor commit ready", {31'd0, bus.cfg_ready}, 1);
      check("nor commit valid", {31'd0, bus.out_valid}, 0);
      check("nor commit out held", {31'd0, bus.out}, 1);
      settle_wait("nor commit+change", 1'b1);
      check("nor err sticky", {31'd0, bus.cfg_err}, 1);
      apply_in("nor in15", 4'd15, 1'b1);
      settle_wait("nor in15", 1'b0);

      // Asynchronous reset mid-load and mid-settle.
      bus.in = 4'd9;
      send_bit("rst load", 1'b1, 1'b0);
      send_bit("rst load", 1'b0, 1'b0);
      send_bit("rst load", 1'b1, 1'b0);
      check("rst pre valid", {31'd0, bus.out_valid}, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async out", {31'd0, bus.out}, 0);
      check("rst async valid", {31'd0, bus.out_valid}, 0);
      check("rst async ready", {31'd0, bus.cfg_ready}, 1);
      check("rst async err", {31'd0, bus.cfg_err}, 0);
      bus.cfg_valid = 1'b0;
      step();
      check("rst held valid", {31'd0, bus.out_valid}, 0);
      rst_n = 1'b1;
      step();
      check("rst rel valid", {31'd0, bus.out_valid}, 0);
      settle_wait("rst in9 init table", 1'b1);

      // Bit at the last index without cfg_last is a framing error too.
      for (int i = 0; i < 16; i++) begin
         send_bit("nolast", 1'b0, 1'b0);
         if (i == 14) check("nolast err at 14", {31'd0, bus.cfg_err}, 0);
      end
      bus.cfg_valid = 1'b0;
      check("nolast cfg_err", {31'd0, bus.cfg_err}, 1);
      step();
      check("nolast no commit", {31'd0, bus.cfg_ready}, 1);
      apply_in("nolast in8", 4'd8, 1'b1);
      settle_wait("nolast in8", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
